data_memory: RTL and testbench

Data-memory responder for the five-stage pipeline. It answers the MEM stage's `MEM_mem_addr`, `MEM_mem_cmd` and `MEM_mem_din` request with `DM_mem_dout`, and backs that request with a word-organised RAM that supports byte-lane writes. It also decodes a small memory-mapped I/O window that holds a free-running 64-bit cycle counter and a tohost/halt register, and keeps sticky error flags for misaligned and out-of-range accesses.

---
 rtl/data_memory.sv | 199 +++++++++++++++++++
 tb/tb_data_memory.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Data-memory responder for the MEM stage: word-organised RAM with byte-lane
// writes, a small MMIO window (cycle counter, tohost/halt) and sticky error flags.
module data_memory #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] MEM_mem_addr,
  input  logic [3:0]  MEM_mem_cmd,
  input  logic [31:0] MEM_mem_din,
  output logic [31:0] DM_mem_dout,
  output logic        DM_halt,
  output logic [31:0] DM_exit_code,
  output logic [63:0] DM_cycles,
  output logic        DM_err_misalign,
  output logic        DM_err_oob
);

  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH) * 33'd4;

  typedef enum logic [3:0] {
    CMD_NONE = 4'd0,
    CMD_LB   = 4'd1,
    CMD_LH   = 4'd2,
    CMD_LW   = 4'd3,
    CMD_LBU  = 4'd4,
    CMD_LHU  = 4'd5,
    CMD_SB   = 4'd8,
    CMD_SH   = 4'd9,
    CMD_SW   = 4'd10
  } mem_cmd_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  mem_cmd_e   cmd;
  logic       is_load;
  logic       is_store;
  logic       sext;
  size_e      size;

  logic       hit_ram;
  logic       hit_cyc_lo;
  logic       hit_cyc_hi;
  logic       hit_tohost;
  logic       hit_mmio;
  logic       active;
  logic       misalign;
  logic       oob;
  logic       access_ok;

  logic [IDX_W-1:0] ram_idx;
  logic [31:0]      rd_word;
  logic [7:0]       lane_byte;
  logic [15:0]      lane_half;
  logic [31:0]      load_data;

  logic [3:0]       wr_be;
  logic [31:0]      wr_data;
  logic             ram_we;
  logic             tohost_we;

  logic [31:0] mem [DEPTH];

  assign cmd = mem_cmd_e'(MEM_mem_cmd);

  // NOTE: every variable driven here gets a default first so no path leaves
  // it unassigned; that is what keeps combinational blocks from inferring latches.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sext     = 1'b0;
    size     = SZ_W;
    case (cmd)
      CMD_LB:  begin is_load  = 1'b1; size = SZ_B; sext = 1'b1; end
      CMD_LH:  begin is_load  = 1'b1; size = SZ_H; sext = 1'b1; end
      CMD_LW:  begin is_load  = 1'b1; size = SZ_W;              end
      CMD_LBU: begin is_load  = 1'b1; size = SZ_B;              end
      CMD_LHU: begin is_load  = 1'b1; size = SZ_H;              end
      CMD_SB:  begin is_store = 1'b1; size = SZ_B;              end
      CMD_SH:  begin is_store = 1'b1; size = SZ_H;              end
      CMD_SW:  begin is_store = 1'b1; size = SZ_W;              end
      default: ;
    endcase
  end

  assign hit_ram    = ({1'b0, MEM_mem_addr} < RAM_BYTES);
  assign hit_cyc_lo = (MEM_mem_addr == MMIO_BASE);
  assign hit_cyc_hi = (MEM_mem_addr == MMIO_BASE + 32'd4);
  assign hit_tohost = (MEM_mem_addr == MMIO_BASE + 32'd8);
  assign hit_mmio   = hit_cyc_lo | hit_cyc_hi | hit_tohost;
  assign active     = is_load | is_store;

  // Alignment wins over range: an access that is both only raises misalign.
  assign misalign  = active &&
                     (((size == SZ_H) && MEM_mem_addr[0]) ||
                      ((size == SZ_W) && (MEM_mem_addr[1:0] != 2'b00)) ||
                      ((size != SZ_W) && hit_mmio));
  assign oob       = active && !misalign && !hit_ram && !hit_mmio;
  assign access_ok = active && !misalign && !oob;

  assign ram_idx = MEM_mem_addr[IDX_W+1:2];
  assign rd_word = mem[ram_idx];

  always_comb begin
    lane_byte = rd_word[7:0];
    case (MEM_mem_addr[1:0])
      2'd0: lane_byte = rd_word[7:0];
      2'd1: lane_byte = rd_word[15:8];
      2'd2: lane_byte = rd_word[23:16];
      2'd3: lane_byte = rd_word[31:24];
      default: ;
    endcase
    lane_half = MEM_mem_addr[1] ? rd_word[31:16] : rd_word[15:0];
  end

  always_comb begin
    load_data = '0;
    if (is_load && access_ok) begin
      if (hit_cyc_lo) begin
        load_data = DM_cycles[31:0];
      end else if (hit_cyc_hi) begin
        load_data = DM_cycles[63:32];
      end else if (hit_tohost) begin
        load_data = DM_exit_code;
      end else begin
        case (size)
          SZ_B:    load_data = sext ? {{24{lane_byte[7]}}, lane_byte}
                                    : {24'd0, lane_byte};
          SZ_H:    load_data = sext ? {{16{lane_half[15]}}, lane_half}
                                    : {16'd0, lane_half};
          default: load_data = rd_word;
        endcase
      end
    end
  end

  assign DM_mem_dout = load_data;

  // Store data is replicated across lanes so the byte enable alone picks the target.
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = MEM_mem_din;
    case (size)
      SZ_B: begin
        wr_be   = 4'b0001 << MEM_mem_addr[1:0];
        wr_data = {4{MEM_mem_din[7:0]}};
      end
      SZ_H: begin
        wr_be   = MEM_mem_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{MEM_mem_din[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = MEM_mem_din;
      end
    endcase
  end

  assign ram_we    = rst_n && is_store && access_ok && hit_ram;
  assign tohost_we = is_store && access_ok && hit_tohost && !DM_halt;

  // NOTE: the RAM array has no reset branch; clearing a memory on reset would
  // force it into flops. The write is gated by rst_n instead so a store that
  // overlaps reset is dropped.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[ram_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DM_cycles       <= '0;
      DM_halt         <= 1'b0;
      DM_exit_code    <= '0;
      DM_err_misalign <= 1'b0;
      DM_err_oob      <= 1'b0;
    end else begin
      DM_cycles <= DM_cycles + 64'd1;
      if (misalign) DM_err_misalign <= 1'b1;
      if (oob)      DM_err_oob      <= 1'b1;
      if (tohost_we) begin
        DM_halt      <= 1'b1;
        DM_exit_code <= MEM_mem_din;
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: stimulus pushes expected observations into a
// scoreboard queue, a negedge monitor pops and compares them against the DUT.
module tb_data_memory;

  localparam logic [31:0] MMIO   = 32'hFFFF_FFF0;
  localparam logic [31:0] CYC_LO = MMIO;
  localparam logic [31:0] CYC_HI = MMIO + 32'd4;
  localparam logic [31:0] TOHOST = MMIO + 32'd8;

  localparam logic [3:0] C_NONE = 4'd0;
  localparam logic [3:0] C_LB   = 4'd1;
  localparam logic [3:0] C_LH   = 4'd2;
  localparam logic [3:0] C_LW   = 4'd3;
  localparam logic [3:0] C_LBU  = 4'd4;
  localparam logic [3:0] C_LHU  = 4'd5;
  localparam logic [3:0] C_SB   = 4'd8;
  localparam logic [3:0] C_SH   = 4'd9;
  localparam logic [3:0] C_SW   = 4'd10;

  typedef enum {K_DOUT, K_HALT, K_EXIT, K_MIS, K_OOB, K_CYC} kind_e;
  typedef struct {
    kind_e       kind;
    logic [63:0] val;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic [3:0]  mem_cmd;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        halt;
  logic [31:0] exit_code;
  logic [63:0] cycles;
  logic        err_misalign;
  logic        err_oob;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc_n    = 0;

  data_memory #(.DEPTH(1024), .MMIO_BASE(MMIO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .MEM_mem_addr    (mem_addr),
    .MEM_mem_cmd     (mem_cmd),
    .MEM_mem_din     (mem_din),
    .DM_mem_dout     (mem_dout),
    .DM_halt         (halt),
    .DM_exit_code    (exit_code),
    .DM_cycles       (cycles),
    .DM_err_misalign (err_misalign),
    .DM_err_oob      (err_oob)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Monitor: everything queued during a cycle is compared at that cycle's negedge.
  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        K_DOUT:  act = {32'd0, mem_dout};
        K_HALT:  act = {63'd0, halt};
        K_EXIT:  act = {32'd0, exit_code};
        K_MIS:   act = {63'd0, err_misalign};
        K_OOB:   act = {63'd0, err_oob};
        default: act = cycles;
      endcase
      checks++;
      if (act !== e.val) begin
        failures++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val);
      end
    end
  end

  task automatic push(input kind_e k, input logic [63:0] v, input string n);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.name = n;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) cyc_n++;
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    mem_cmd  = c;
    mem_addr = a;
    mem_din  = d;
  endtask

  task automatic op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    step();
    drive(c, a, d);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(C_NONE, 32'd0, 32'd0);

    // Reset state.
    step();
    push(K_DOUT, 64'd0, "dout_in_reset");
    push(K_CYC,  64'd0, "cycles_in_reset");
    push(K_HALT, 64'd0, "halt_in_reset");
    push(K_EXIT, 64'd0, "exit_in_reset");
    push(K_MIS,  64'd0, "mis_in_reset");
    push(K_OOB,  64'd0, "oob_in_reset");

    // Release between edges; this partial cycle is cycle 0.
    step();
    rst_n = 1'b1;
    cyc_n = 0;
    drive(C_LW, CYC_LO, 32'd0);
    push(K_DOUT, 64'd0, "cyc_lo_cycle0");
    for (int i = 0; i < 4; i++) op(C_NONE, 32'd0, 32'd0);
    op(C_LW, CYC_LO, 32'd0);
    push(K_DOUT, 64'd5, "cyc_lo_cycle5");
    op(C_LW, CYC_HI, 32'd0);
    push(K_DOUT, 64'd0, "cyc_hi_zero");

    // Byte-lane store/load.
    op(C_SW, 32'h10, 32'h1122_3344);
    op(C_SB, 32'h12, 32'h0000_00AA);
    op(C_LW,  32'h10, 32'd0); push(K_DOUT, 64'h11AA_3344, "lw_after_sb");
    op(C_LB,  32'h12, 32'd0); push(K_DOUT, 64'hFFFF_FFAA, "lb_sext");
    op(C_LBU, 32'h12, 32'd0); push(K_DOUT, 64'h0000_00AA, "lbu_zext");
    op(C_LH,  32'h12, 32'd0); push(K_DOUT, 64'h0000_11AA, "lh_upper_pos");

    // Half-word sign extension; upper din bits must be ignored.
    op(C_SH, 32'h22, 32'h5555_8001);
    op(C_LH,  32'h22, 32'd0); push(K_DOUT, 64'hFFFF_8001, "lh_sext");
    op(C_LHU, 32'h22, 32'd0); push(K_DOUT, 64'h0000_8001, "lhu_zext");
    op(C_LB,  32'h23, 32'd0); push(K_DOUT, 64'hFFFF_FF80, "lb_lane3");
    op(C_LBU, 32'h22, 32'd0); push(K_DOUT, 64'h0000_0001, "lbu_lane2");

    // Misalignment.
    op(C_SW, 32'h30, 32'hCAFE_F00D);
    op(C_SW, 32'h31, 32'hDEAD_BEEF);
    push(K_MIS, 64'd0, "mis_before_edge");
    op(C_LW, 32'h30, 32'd0);
    push(K_DOUT, 64'hCAFE_F00D, "misaligned_sw_no_write");
    push(K_MIS,  64'd1, "mis_set");
    push(K_OOB,  64'd0, "oob_clear_after_mis");
    op(C_LH, 32'h33, 32'd0); push(K_DOUT, 64'd0, "lh_misaligned_zero");
    op(C_LH, 32'h1001, 32'd0); push(K_DOUT, 64'd0, "lh_oob_misaligned_zero");
    op(C_NONE, 32'd0, 32'd0); push(K_OOB, 64'd0, "oob_not_set_when_misaligned");

    // Last RAM word and OOB boundary (0x1000 aliases word 0 if decoded wrongly).
    op(C_SW, 32'h0, 32'h0102_0304);
    op(C_SW, 32'hFFC, 32'h5A5A_0000);
    op(C_LW, 32'hFFC, 32'd0); push(K_DOUT, 64'h5A5A_0000, "lw_last_word");
    push(K_OOB, 64'd0, "oob_clear_last_word");
    op(C_LW, 32'h1000, 32'd0); push(K_DOUT, 64'd0, "lw_oob_zero");
    op(C_SW, 32'h1000, 32'hFFFF_FFFF); push(K_OOB, 64'd1, "oob_set");
    op(C_LW, 32'h0, 32'd0); push(K_DOUT, 64'h0102_0304, "sw_oob_no_alias");

    // MMIO: sub-word is rejected, counter stores are ignored.
    op(C_LB, CYC_LO, 32'd0); push(K_DOUT, 64'd0, "lb_mmio_zero");
    op(C_SW, CYC_LO, 32'd0);
    op(C_LW, CYC_LO, 32'd0); push(K_DOUT, 64'(cyc_n), "cyc_after_store_ignored");
    push(K_CYC, 64'(cyc_n), "cycles_port");

    // Halt via tohost.
    op(C_SW, TOHOST, 32'h1);
    push(K_HALT, 64'd0, "halt_before_edge");
    op(C_SW, TOHOST, 32'h7);
    push(K_HALT, 64'd1, "halt_set");
    push(K_EXIT, 64'd1, "exit_code_1");
    op(C_LW, TOHOST, 32'd0);
    push(K_DOUT, 64'd1, "lw_tohost");
    push(K_EXIT, 64'd1, "exit_code_kept");

    // Asynchronous reset while a store is pending.
    op(C_SW, 32'h40, 32'h1234_5678);
    step();
    drive(C_SW, 32'h40, 32'h9999_9999);
    #2 rst_n = 1'b0;
    #1;
    push(K_CYC,  64'd0, "async_rst_cycles");
    push(K_HALT, 64'd0, "async_rst_halt");
    push(K_EXIT, 64'd0, "async_rst_exit");
    push(K_MIS,  64'd0, "async_rst_mis");
    push(K_OOB,  64'd0, "async_rst_oob");
    step();
    rst_n = 1'b1;
    cyc_n = 0;
    drive(C_LW, 32'h40, 32'd0);
    push(K_DOUT, 64'h1234_5678, "store_dropped_in_reset");
    push(K_CYC,  64'd0, "cycles_after_rerelease");
    op(C_LW, CYC_LO, 32'd0); push(K_DOUT, 64'd1, "cyc_lo_cycle1");

    step();
    drive(C_NONE, 32'd0, 32'd0);
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
